// File: rtl/datapath_pkg.sv
// Shared definitions for the parametrised bus datapath: bus source offsets,
// memory FSM state type and a helper to size the source set.
package datapath_pkg;

  // Special sources follow the general registers; each SRC_x = NUM_REGS + OFS_x.
  localparam int NUM_SPECIAL_SRCS = 8;
  localparam int OFS_HI     = 0;
  localparam int OFS_LO     = 1;
  localparam int OFS_ZHI    = 2;
  localparam int OFS_ZLO    = 3;
  localparam int OFS_PC     = 4;
  localparam int OFS_MDR    = 5;
  localparam int OFS_INPORT = 6;
  localparam int OFS_C      = 7;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

  function automatic int num_srcs(input int num_regs);
    return num_regs + NUM_SPECIAL_SRCS;
  endfunction

endpackage

// File: rtl/datapath_core_param_bus_source_select.sv
// Bus source arbitration: lowest-index enabled source drives the bus,
// and more than one enable in a cycle flags contention.
module bus_source_select #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRCS = 24
) (
  input  logic [NUM_SRCS-1:0] src_en,
  input  logic [DATA_W-1:0]   src_data [NUM_SRCS],
  output logic [DATA_W-1:0]   bus,
  output logic                bus_conflict
);

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    bus = '0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      if (src_en[i]) bus = src_data[i];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign bus_conflict = (src_en & (src_en - NUM_SRCS'(1))) != '0;

endmodule

// File: rtl/datapath_core_param.sv
// Parametrised single-bus CPU datapath: general registers, special registers,
// contention tracking and a req/ack memory interface driven by MAR/MDR.
module datapath_core_param
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 9
) (
  input  logic                  Clock,
  input  logic                  Clear_n,
  input  logic [NUM_REGS-1:0]   reg_in,
  input  logic [NUM_REGS-1:0]   reg_out,
  input  logic                  ba_out,
  input  logic                  hi_in,
  input  logic                  lo_in,
  input  logic                  pc_in,
  input  logic                  ir_in,
  input  logic                  y_in,
  input  logic                  mar_in,
  input  logic                  mdr_in,
  input  logic                  z_in,
  input  logic                  outport_in,
  input  logic                  hi_out,
  input  logic                  lo_out,
  input  logic                  zhi_out,
  input  logic                  zlo_out,
  input  logic                  pc_out,
  input  logic                  mdr_out,
  input  logic                  inport_out,
  input  logic                  c_out,
  input  logic                  inc_pc,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]     c_value,
  input  logic [DATA_W-1:0]     in_dev,
  input  logic                  strobe,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic [DATA_W-1:0]     bus,
  output logic [DATA_W-1:0]     ir,
  output logic [DATA_W-1:0]     y,
  output logic [DATA_W-1:0]     out_port,
  output logic                  bus_conflict,
  output logic                  conflict_seen,
  output mem_state_t            mem_state
);

  localparam int NUM_SRCS   = num_srcs(NUM_REGS);
  localparam int SRC_HI     = NUM_REGS + OFS_HI;
  localparam int SRC_LO     = NUM_REGS + OFS_LO;
  localparam int SRC_ZHI    = NUM_REGS + OFS_ZHI;
  localparam int SRC_ZLO    = NUM_REGS + OFS_ZLO;
  localparam int SRC_PC     = NUM_REGS + OFS_PC;
  localparam int SRC_MDR    = NUM_REGS + OFS_MDR;
  localparam int SRC_INPORT = NUM_REGS + OFS_INPORT;
  localparam int SRC_C      = NUM_REGS + OFS_C;

  logic [DATA_W-1:0]   gpr [NUM_REGS];
  logic [DATA_W-1:0]   hi, lo, pc, mar, mdr, inport;
  logic [2*DATA_W-1:0] z;
  logic [NUM_SRCS-1:0] src_en;
  logic [DATA_W-1:0]   src_data [NUM_SRCS];
  mem_state_t          state_q, state_d;
  logic                rd_done;

  assign src_en = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out,
                   lo_out, hi_out, reg_out};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src_data[i] = gpr[i];
    // Base-address mode: R0 still wins arbitration but contributes zero.
    if (ba_out) src_data[0] = '0;
    src_data[SRC_HI]     = hi;
    src_data[SRC_LO]     = lo;
    src_data[SRC_ZHI]    = z[2*DATA_W-1:DATA_W];
    src_data[SRC_ZLO]    = z[DATA_W-1:0];
    src_data[SRC_PC]     = pc;
    src_data[SRC_MDR]    = mdr;
    src_data[SRC_INPORT] = inport;
    src_data[SRC_C]      = c_value;
  end

  bus_source_select #(
    .DATA_W   (DATA_W),
    .NUM_SRCS (NUM_SRCS)
  ) u_bus_sel (
    .src_en       (src_en),
    .src_data     (src_data),
    .bus          (bus),
    .bus_conflict (bus_conflict)
  );

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i]) gpr[i] <= bus;
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      hi            <= '0;
      lo            <= '0;
      z             <= '0;
      pc            <= '0;
      ir            <= '0;
      y             <= '0;
      mar           <= '0;
      mdr           <= '0;
      inport        <= '0;
      out_port      <= '0;
      conflict_seen <= 1'b0;
    end else begin
      if (hi_in)      hi       <= bus;
      if (lo_in)      lo       <= bus;
      if (z_in)       z        <= alu_result;
      if (ir_in)      ir       <= bus;
      if (y_in)       y        <= bus;
      if (outport_in) out_port <= bus;
      if (strobe)     inport   <= in_dev;
      if (pc_in)       pc <= bus;
      else if (inc_pc) pc <= pc + DATA_W'(1);
      // Address and write data are frozen while a transaction is in flight.
      if (mar_in && !busy) mar <= bus;
      if (rd_done)                                 mdr <= mem_rdata;
      else if (mdr_in && state_q != MEM_WR_WAIT)   mdr <= bus;
      if (bus_conflict) conflict_seen <= 1'b1;
    end
  end

  // Memory handshake: mem_req holds from the cycle after mem_rd/mem_wr up to
  // and including the cycle mem_ack is sampled high; the transfer completes on
  // that edge and a new request is accepted in the following IDLE cycle.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) state_q <= MEM_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_rd)      state_d = MEM_RD_WAIT;
        else if (mem_wr) state_d = MEM_WR_WAIT;
      end
      MEM_RD_WAIT: if (mem_ack) state_d = MEM_IDLE;
      MEM_WR_WAIT: if (mem_ack) state_d = MEM_IDLE;
      default: state_d = MEM_IDLE;
    endcase
  end

  assign rd_done   = (state_q == MEM_RD_WAIT) && mem_ack;
  assign mem_req   = (state_q != MEM_IDLE);
  assign busy      = mem_req;
  assign mem_we    = (state_q == MEM_WR_WAIT);
  assign mem_wdata = mdr;
  assign mem_state = state_q;

  generate
    if (ADDR_W <= DATA_W) begin : g_addr_slice
      assign mem_addr = mar[ADDR_W-1:0];
    end else begin : g_addr_ext
      assign mem_addr = {{(ADDR_W-DATA_W){1'b0}}, mar};
    end
  endgenerate

endmodule

// File: tb/tb_datapath_core_param.sv
// Bench for datapath_core_param: directed scenarios then random cycles, all
// checked against a behavioural model of the register/bus/memory rules.
module tb_datapath_core_param;
  import datapath_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Clear_n = 1'b0;
  always #5 Clock = ~Clock;

  logic [NR-1:0]   reg_in, reg_out;
  logic            ba_out, hi_in, lo_in, pc_in, ir_in, y_in, mar_in, mdr_in, z_in, outport_in;
  logic            hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic            inc_pc, strobe, mem_rd, mem_wr, mem_ack;
  logic [2*DW-1:0] alu_result;
  logic [DW-1:0]   c_value, in_dev, mem_rdata;
  logic            mem_req, mem_we, busy, bus_conflict, conflict_seen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, bus, ir, y, out_port;
  mem_state_t      mem_state;

  datapath_core_param #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .Clock(Clock), .Clear_n(Clear_n), .reg_in(reg_in), .reg_out(reg_out), .ba_out(ba_out),
    .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .z_in(z_in), .outport_in(outport_in),
    .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .inc_pc(inc_pc), .alu_result(alu_result), .c_value(c_value), .in_dev(in_dev),
    .strobe(strobe), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .bus(bus), .ir(ir), .y(y), .out_port(out_port),
    .bus_conflict(bus_conflict), .conflict_seen(conflict_seen), .mem_state(mem_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]   m_regs [NR];
  logic [DW-1:0]   m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr, m_inport, m_outport;
  logic [2*DW-1:0] m_z;
  bit              m_seen, m_busy, m_is_wr;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0;
    m_mdr = '0; m_inport = '0; m_outport = '0; m_z = '0;
    m_seen = 0; m_busy = 0; m_is_wr = 0;
  endtask

  function automatic logic [DW-1:0] source_value(input int idx);
    if (idx < NR) return (idx == 0 && ba_out) ? '0 : m_regs[idx];
    case (idx - NR)
      0: return m_hi;
      1: return m_lo;
      2: return m_z[2*DW-1:DW];
      3: return m_z[DW-1:0];
      4: return m_pc;
      5: return m_mdr;
      6: return m_inport;
      default: return c_value;
    endcase
  endfunction

  // Drivers are listed in source order; the first one owns the bus.
  task automatic model_bus(output logic [DW-1:0] v, output bit conf);
    int drivers[$];
    logic special_en [8];
    special_en = '{hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out};
    for (int i = 0; i < NR; i++) if (reg_out[i]) drivers.push_back(i);
    for (int i = 0; i < 8; i++) if (special_en[i]) drivers.push_back(NR + i);
    v = (drivers.size() == 0) ? '0 : source_value(drivers[0]);
    conf = drivers.size() > 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    reg_in = '0; reg_out = '0; ba_out = 0;
    hi_in = 0; lo_in = 0; pc_in = 0; ir_in = 0; y_in = 0; mar_in = 0; mdr_in = 0;
    z_in = 0; outport_in = 0;
    hi_out = 0; lo_out = 0; zhi_out = 0; zlo_out = 0; pc_out = 0; mdr_out = 0;
    inport_out = 0; c_out = 0;
    inc_pc = 0; strobe = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0;
  endtask

  // Checks every visible output against the model, then applies one edge.
  task automatic cycle();
    logic [DW-1:0] bv;
    bit cf;
    mem_state_t exp_state;
    #1;
    model_bus(bv, cf);
    exp_state = !m_busy ? MEM_IDLE : (m_is_wr ? MEM_WR_WAIT : MEM_RD_WAIT);
    check("bus", bus, bv);
    check("bus_conflict", bus_conflict, cf);
    check("conflict_seen", conflict_seen, m_seen);
    check("mem_req", mem_req, m_busy);
    check("busy", busy, m_busy);
    check("mem_we", mem_we, m_busy && m_is_wr);
    check("mem_state", 64'(mem_state), 64'(exp_state));
    check("mem_addr", mem_addr, m_mar[AW-1:0]);
    check("mem_wdata", mem_wdata, m_mdr);
    check("ir", ir, m_ir);
    check("y", y, m_y);
    check("out_port", out_port, m_outport);
    for (int i = 0; i < NR; i++) if (reg_in[i]) m_regs[i] = bv;
    if (hi_in) m_hi = bv;
    if (lo_in) m_lo = bv;
    if (ir_in) m_ir = bv;
    if (y_in) m_y = bv;
    if (outport_in) m_outport = bv;
    if (z_in) m_z = alu_result;
    if (strobe) m_inport = in_dev;
    if (pc_in) m_pc = bv;
    else if (inc_pc) m_pc = m_pc + 1;
    if (mar_in && !m_busy) m_mar = bv;
    if (m_busy && !m_is_wr && mem_ack) m_mdr = mem_rdata;
    else if (mdr_in && !(m_busy && m_is_wr)) m_mdr = bv;
    if (!m_busy) begin
      if (mem_rd) begin m_busy = 1; m_is_wr = 0; end
      else if (mem_wr) begin m_busy = 1; m_is_wr = 1; end
    end else if (mem_ack) begin
      m_busy = 0;
    end
    if (cf) m_seen = 1;
    @(posedge Clock);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    clear_inputs();
    #2 Clear_n = 0;
    #1;
    model_reset();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_state", 64'(mem_state), 64'(MEM_IDLE));
    check("rst_seen", conflict_seen, 1'b0);
    check("rst_bus", bus, '0);
    @(posedge Clock);
    #1 Clear_n = 1;
  endtask

  task automatic load_const(input logic [DW-1:0] v);
    c_value = v; c_out = 1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear_inputs();
    alu_result = '0; c_value = '0; in_dev = '0; mem_rdata = '0;
    model_reset();
    #1;
    do_reset();

    // Contention: R3 and HI together, R3 wins.
    load_const(32'h33); reg_in[3] = 1; cycle(); clear_inputs();
    reg_out[3] = 1; hi_out = 1; #1;
    check("r3_hi_bus", bus, 32'h33);
    check("r3_hi_conflict", bus_conflict, 1'b1);
    cycle(); clear_inputs();
    check("seen_set", conflict_seen, 1'b1);
    cycle(); cycle();
    check("seen_sticky", conflict_seen, 1'b1);

    // Base-address mode on R0.
    load_const(32'h55); reg_in[0] = 1; cycle(); clear_inputs();
    reg_out[0] = 1; ba_out = 1; #1;
    check("ba_zero", bus, 32'h0);
    cycle(); clear_inputs();
    reg_out[0] = 1; #1;
    check("r0_value", bus, 32'h55);
    cycle(); clear_inputs();

    // PC wrap and pc_in priority over inc_pc.
    load_const(32'hFFFF_FFFF); pc_in = 1; cycle(); clear_inputs();
    inc_pc = 1; cycle(); clear_inputs();
    pc_out = 1; #1;
    check("pc_wrap", bus, 32'h0);
    cycle(); clear_inputs();
    load_const(32'h40); pc_in = 1; inc_pc = 1; cycle(); clear_inputs();
    pc_out = 1; #1;
    check("pc_in_prio", bus, 32'h40);
    cycle(); clear_inputs();

    // Read with three wait cycles; MAR writes during the wait are dropped.
    load_const(32'h1A3); mar_in = 1; cycle(); clear_inputs();
    mem_rd = 1; cycle(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      load_const(32'h0F0); mar_in = 1; #1;
      check("rd_busy", busy, 1'b1);
      check("rd_addr", mem_addr, 9'h1A3);
      cycle(); clear_inputs();
    end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; load_const(32'h777); mdr_in = 1; #1;
    check("rd_addr_ack", mem_addr, 9'h1A3);
    check("rd_req_ack", mem_req, 1'b1);
    cycle(); clear_inputs();
    check("rd_busy_after", busy, 1'b0);
    mdr_out = 1; #1;
    check("rd_mdr", bus, 32'hDEAD_BEEF);
    cycle(); clear_inputs();

    // Write: MDR is frozen in WR_WAIT.
    load_const(32'h1234); mdr_in = 1; cycle(); clear_inputs();
    mem_wr = 1; cycle(); clear_inputs();
    for (int i = 0; i < 2; i++) begin
      load_const(32'h9999); mdr_in = 1; #1;
      check("wr_wdata", mem_wdata, 32'h1234);
      check("wr_we", mem_we, 1'b1);
      cycle(); clear_inputs();
    end
    mem_ack = 1; #1;
    check("wr_we_ack", mem_we, 1'b1);
    cycle(); clear_inputs();
    check("wr_we_after", mem_we, 1'b0);
    check("wr_wdata_after", mem_wdata, 32'h1234);

    // Reset during RD_WAIT aborts; a later ack is ignored.
    mem_rd = 1; cycle(); clear_inputs();
    cycle();
    do_reset();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; cycle(); clear_inputs();
    mdr_out = 1; #1;
    check("abort_mdr", bus, 32'h0);
    cycle(); clear_inputs();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      for (int i = 0; i < NR; i++) reg_out[i] = ($urandom_range(0, 19) == 0);
      hi_out = ($urandom_range(0, 19) == 0);  lo_out = ($urandom_range(0, 19) == 0);
      zhi_out = ($urandom_range(0, 19) == 0); zlo_out = ($urandom_range(0, 19) == 0);
      pc_out = ($urandom_range(0, 19) == 0);  mdr_out = ($urandom_range(0, 19) == 0);
      inport_out = ($urandom_range(0, 19) == 0); c_out = ($urandom_range(0, 9) == 0);
      ba_out = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) reg_in[$urandom_range(0, NR - 1)] = 1'b1;
      hi_in = ($urandom_range(0, 3) == 0); lo_in = ($urandom_range(0, 3) == 0);
      pc_in = ($urandom_range(0, 3) == 0); ir_in = ($urandom_range(0, 3) == 0);
      y_in = ($urandom_range(0, 3) == 0);  mar_in = ($urandom_range(0, 3) == 0);
      mdr_in = ($urandom_range(0, 3) == 0); z_in = ($urandom_range(0, 3) == 0);
      outport_in = ($urandom_range(0, 3) == 0); inc_pc = ($urandom_range(0, 2) == 0);
      strobe = ($urandom_range(0, 3) == 0);
      mem_rd = ($urandom_range(0, 5) == 0); mem_wr = ($urandom_range(0, 5) == 0);
      mem_ack = ($urandom_range(0, 2) == 0);
      alu_result = {$urandom, $urandom};
      c_value = $urandom; in_dev = $urandom; mem_rdata = $urandom;
      cycle();
      clear_inputs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
